// File: rtl/game_pkg.sv
// Shared game geometry, field widths and the per-slot state record used by the
// falling-object logic.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int OBJ_W    = 16;
  localparam int OBJ_H    = 16;
  localparam int NUM_OBJ  = 6;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int R_W      = 9;
  localparam int CNT_W    = 6;

  // An object is retired once its top edge reaches this line.
  localparam logic [Y_W-1:0] Y_LIMIT = Y_W'(SCREEN_H - OBJ_H);

  typedef struct packed {
    logic           active;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } slot_t;

  // Zero-extend the random value and shift it right by the playfield margin.
  function automatic logic [X_W-1:0] spawn_x(input logic [R_W-1:0] r,
                                             input int             offset);
    return X_W'(r) + X_W'(offset);
  endfunction

endpackage

// File: rtl/obj_slot.sv
// One falling-object slot: holds active/x/y, loads on spawn, falls on move,
// retires at the bottom edge or on kill.
module obj_slot
  import game_pkg::*;
#(
  parameter int FALL_STEP = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           move,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  input  logic           kill,
  output logic           active,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           bottom_hit
);

  slot_t          cur;
  slot_t          nxt;
  logic           hit_next;
  logic [Y_W-1:0] y_step;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    nxt      = cur;
    hit_next = 1'b0;
    y_step   = cur.y + Y_W'(FALL_STEP);
    // load only ever targets an inactive slot, so it cannot collide with kill/move.
    if (load) begin
      nxt.active = 1'b1;
      nxt.x      = load_x;
      nxt.y      = '0;
    end else if (cur.active && kill) begin
      nxt.active = 1'b0;
    end else if (cur.active && move) begin
      nxt.y = y_step;
      if (y_step >= Y_LIMIT) begin
        nxt.active = 1'b0;
        hit_next   = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so all slots update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= '0;
      bottom_hit <= 1'b0;
    end else begin
      cur        <= nxt;
      bottom_hit <= hit_next;
    end
  end

  assign active = cur.active;
  assign x      = cur.x;
  assign y      = cur.y;

endmodule

// File: rtl/obstacle_spawner.sv
// Spawns up to NUM_OBJ falling objects on a frame timer and moves them down.
// Optional build macro SPAWN_RAMP_EN shortens the spawn period every 8 spawns.
module obstacle_spawner
  import game_pkg::*;
#(
  parameter int X_OFFSET     = 64,
  parameter int SPAWN_PERIOD = 60,
  parameter int SPAWN_MIN    = 15,
  parameter int FALL_STEP    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic                   enable,
  input  logic [R_W-1:0]         rand_num0,
  input  logic [R_W-1:0]         rand_num1,
  input  logic [R_W-1:0]         rand_num2,
  input  logic [R_W-1:0]         rand_num3,
  input  logic [R_W-1:0]         rand_num4,
  input  logic [R_W-1:0]         rand_num5,
  input  logic [NUM_OBJ-1:0]     kill,
  output logic [NUM_OBJ-1:0]     obj_active,
  output logic [NUM_OBJ*X_W-1:0] obj_x,
  output logic [NUM_OBJ*Y_W-1:0] obj_y,
  output logic                   spawn_pulse,
  output logic [NUM_OBJ-1:0]     bottom_hit
);

  logic                 tick;
  logic                 at_wrap;
  logic                 found;
  logic                 spawn;
  logic [CNT_W-1:0]     frame_cnt;
  logic [CNT_W-1:0]     period;
  logic [NUM_OBJ-1:0]   sel_oh;
  logic [NUM_OBJ-1:0]   load_vec;
  logic [R_W-1:0]       rand_arr [NUM_OBJ];

  assign rand_arr[0] = rand_num0;
  assign rand_arr[1] = rand_num1;
  assign rand_arr[2] = rand_num2;
  assign rand_arr[3] = rand_num3;
  assign rand_arr[4] = rand_num4;
  assign rand_arr[5] = rand_num5;

  assign tick    = frame_tick & enable;
  assign at_wrap = (frame_cnt == period - CNT_W'(1));

  // Lowest-index free slot, judged on the state before this edge.
  always_comb begin
    sel_oh = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (!obj_active[i] && !found) begin
        sel_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign spawn    = tick && at_wrap && found;
  assign load_vec = spawn ? sel_oh : '0;

  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_slot
    obj_slot #(
      .FALL_STEP (FALL_STEP)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .move       (tick),
      .load       (load_vec[i]),
      .load_x     (spawn_x(rand_arr[i], X_OFFSET)),
      .kill       (kill[i]),
      .active     (obj_active[i]),
      .x          (obj_x[X_W*i +: X_W]),
      .y          (obj_y[Y_W*i +: Y_W]),
      .bottom_hit (bottom_hit[i])
    );
  end

  // The counter wraps on the attempt tick even when every slot is busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      spawn_pulse <= 1'b0;
    end else begin
      spawn_pulse <= spawn;
      if (tick) begin
        frame_cnt <= at_wrap ? '0 : frame_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SPAWN_RAMP_EN
  logic [2:0] spawn_cnt;

  // The shortened period applies from the interval that starts at this spawn.
  always_ff @(posedge clk) begin
    if (rst) begin
      spawn_cnt <= '0;
      period    <= CNT_W'(SPAWN_PERIOD);
    end else if (spawn) begin
      spawn_cnt <= spawn_cnt + 3'd1;
      if (spawn_cnt == 3'd7 && period > CNT_W'(SPAWN_MIN)) begin
        period <= period - CNT_W'(1);
      end
    end
  end
`else
  assign period = CNT_W'(SPAWN_PERIOD);
`endif

endmodule

// File: doc/obstacle_spawner.md
# obstacle_spawner

Consumes the six 9-bit pseudo-random values from the LFSR stage and turns them into up to six falling game objects: spawns an object at a random horizontal position on a frame-based timer, moves active objects down once per frame, and retires them at the bottom edge or on a kill request from collision logic. Sits between the random generator and the VGA object renderer / collision checker.

## Interface
- SCREEN_H, 480, visible lines
- OBJ_H, 16, object height in pixels
- X_OFFSET, 64, added to the random value to form x
- SPAWN_PERIOD, 60, frames between spawn attempts (reset value of the period)
- SPAWN_MIN, 15, minimum period when ramping
- FALL_STEP, 2, pixels moved per frame
- clk  in  1  system clock
- rst  in  1  reset; rst synchronous, active-high; clock clk
- frame_tick  in  1  one-cycle pulse per video frame
- enable  in  1  1 = run, 0 = pause
- rand_num0..rand_num5  in  9 each  random values; slot i uses rand_num_i
- kill  in  6  per-slot deactivate request from collision logic
- obj_active  out  6  per-slot active flag
- obj_x  out  60  slot i at [10i+9:10i], pixel x
- obj_y  out  54  slot i at [9i+8:9i], pixel y
- spawn_pulse  out  1  one-cycle pulse when a spawn occurred
- bottom_hit  out  6  one-cycle per-slot pulse when an object reaches the bottom

## Operation
- Reset: obj_active=0, obj_x=0, obj_y=0, spawn_pulse=0, bottom_hit=0, frame counter=0, period=SPAWN_PERIOD.
- Frame counter advances on frame_tick when enable=1; frozen when enable=0.
- Spawn attempt on the frame_tick where counter == period-1: counter returns to 0; lowest-index slot with obj_active=0 is loaded with x = rand_num_i + X_OFFSET (zero-extended to 10 bits, range 64..575), y=0, active=1; spawn_pulse=1. All slots active: no spawn, no spawn_pulse, counter still wraps.
- Move: on every frame_tick with enable=1, each slot active before that tick and not just spawned gets y_next = y + FALL_STEP. If y_next >= SCREEN_H-OBJ_H (464): active cleared, y stored as y_next, bottom_hit[i]=1 for one cycle.
- kill[i]=1 (any cycle, regardless of enable): active[i] cleared next edge; kill overrides move and bottom_hit for that slot; kill on an inactive slot is ignored. Spawn selects among slots inactive before the edge, so a same-cycle kill never blocks or cancels a spawn.
- Inactive slots hold their last x/y; renderer must gate on obj_active.
- enable=0: no move, no spawn; kill still honoured.

## Timing
- All outputs registered; updates visible the cycle after the frame_tick/kill cycle.
- spawn_pulse and bottom_hit are exactly one cycle wide.
- rand_num sampled only in the spawn cycle; no handshake.
- rst mid-operation returns everything to reset values on the next edge, discarding pending pulses.

## Configuration
- SPAWN_RAMP_EN defined: every 8th successful spawn decrements period by 1, saturating at SPAWN_MIN; decrement takes effect for the next counting interval.
- Undefined: period fixed at SPAWN_PERIOD; no spawn counter logic present.

## Structure
- Shared package game_pkg: SCREEN_W, SCREEN_H, OBJ_W, OBJ_H, NUM_OBJ=6, X_W=10, Y_W=9.
- Sub-module obj_slot: one slot's active/x/y registers, load, move, bottom detect and kill; instantiated 6 times. Top holds frame counter, period/ramp logic and lowest-free-slot priority encoder.

## Test plan
- Reset, enable=1, rand_num0=100, 60 frame_ticks -> spawn_pulse after 60th, obj_active=6'b000001, x0=164, y0=0.
- Continue 232 ticks -> y0 reaches 464, obj_active[0]=0, bottom_hit[0] one-cycle pulse.
- Fill all six slots (spawn every 60 ticks), next period -> no spawn_pulse, counter wraps, slots unchanged.
- kill[2] same cycle as a move tick -> slot 2 inactive, no bottom_hit[2]; next spawn reuses slot 2 with x=rand_num2+64.
- enable=0 for 100 ticks -> y and counter frozen; kill[0] still clears slot 0.
- SPAWN_RAMP_EN: after 8 spawns next spawn interval is 59 ticks; after 45 decrements period stays 15.
